text_writer: RTL and testbench
==============================

Name: text_writer

Overview:
- Upstream producer for the character text RAM's write port. The display pipeline reads that RAM through its read port.
- Accepts a byte stream (e.g. from a UART receiver) over a valid/ready handshake and turns it into write-port cycles.
- Keeps a cursor and interprets a small set of control codes: CR, LF, BS, FF.
- Clears the screen to spaces on reset, and clears each new line as the cursor enters it. This makes the text buffer behave as a simple wrap-around terminal.

Parameters:
- COLS, 40, characters per row (640 px / 16 px at zoom 1); max 128
- ROWS, 30, rows per screen (480 px / 16 px at zoom 1); max 128
- ADDR_WIDTH, 11, RAM address width; must satisfy 2**ADDR_WIDTH >= COLS*ROWS
- BLANK, 8'h20, character code written when clearing

Ports:
- clk  in  1  system/pixel clock; same clock as the RAM write port (wclk)
- rst  in  1  synchronous, active-high reset
- char_in  in  8  incoming character code
- char_valid  in  1  char_in is valid
- char_ready  out  1  block accepts char_in this cycle
- ram_waddr  out  ADDR_WIDTH  RAM write address = row*COLS + col
- ram_wdata  out  8  RAM write data
- ram_we  out  1  RAM write enable
- cursor_col  out  7  current cursor column, 0..COLS-1
- cursor_row  out  7  current cursor row, 0..ROWS-1

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst). All outputs are registered except char_ready.
- char_ready = (state == IDLE). A transfer occurs when char_valid && char_ready are both high.
- Reset values: state=CLEAR, clear counter=0, cursor=(0,0), ram_we=0, ram_waddr=0, ram_wdata=0.
- char_ready is 0 during and after reset until CLEAR completes.
- States: CLEAR, IDLE, CLRLINE.
- CLEAR:
  - Starts on the first cycle after rst deasserts.
  - Each cycle registers ram_we=1, ram_waddr=k, ram_wdata=BLANK for k=0..COLS*ROWS-1, giving exactly COLS*ROWS consecutive write cycles.
  - When the write of address COLS*ROWS-1 is issued, the next state is IDLE.
  - Cursor is held at (0,0).
- IDLE: ram_we=0 unless a transfer occurred on the previous cycle. Decode of an accepted char_in:
  - 0x0D (CR): col=0, no write.
  - 0x0A (LF): col=0, row advance.
  - 0x08 (BS):
    - col>0: col=col-1, and one write of BLANK at the new cursor address.
    - col==0: no write, no cursor change.
  - 0x0C (FF): cursor=(0,0), enter CLEAR (full COLS*ROWS clear, same as reset).
  - Any other code < 0x20 or == 0x7F: ignored (no write, no cursor change).
  - All other codes:
    - Write char_in at the current cursor address.
    - col<COLS-1: col=col+1.
    - col==COLS-1: col=0 and row advance (auto-wrap).
- Write timing: ram_we/ram_waddr/ram_wdata are asserted on the cycle after acceptance, for exactly one cycle. The address uses the cursor value before the update.
- Throughput: one printable character per cycle while no row advance occurs.
- Row advance:
  - row = (row==ROWS-1) ? 0 : row+1; no scrolling.
  - Enter CLRLINE for the new row.
  - If the advance comes from a printable at the last column, the printable's write is issued first, on the cycle after acceptance. CLRLINE writes follow on the next cycles.
- CLRLINE:
  - COLS consecutive write cycles of BLANK at new_row*COLS + 0..COLS-1.
  - Then IDLE.
  - char_ready=0 throughout.
- Cursor outputs update on the cycle after acceptance (registered).
- Address arithmetic: row*COLS+col is computed at ADDR_WIDTH bits; no overflow for legal parameters.
- rst at any time, including mid-CLEAR or mid-CLRLINE, aborts the operation and restarts CLEAR from address 0 with cursor (0,0).
- char_valid while char_ready=0: input is not consumed. The producer must hold char_in until accepted.

Test Plan:
- Reset release with COLS=40, ROWS=30 -> ram_we high for exactly 1200 consecutive cycles, ram_waddr 0..1199 in order, ram_wdata=0x20 throughout, char_ready=0 during the clear. char_ready=1 on the cycle after the last clear write; cursor=(0,0).
- After clear, send 0x41 then 0x42 back-to-back -> writes (addr 0, 0x41) then (addr 1, 0x42) on consecutive cycles; cursor_col=2, cursor_row=0.
- Send 40 bytes 0x78 from (0,0) -> writes at addresses 0..39. Then char_ready=0 for 40 cycles while BLANK is written to addresses 40..79. Cursor=(0,1), then char_ready=1.
- Cursor at (5,2), send 0x08 -> single write (addr 84, 0x20), cursor=(4,2). With cursor at (0,2), send 0x08 -> no write, cursor unchanged.
- Cursor at (7,29), send 0x0A -> cursor=(0,0); BLANK written to addresses 0..39. Send 0x0D at (9,3) -> cursor=(0,3), no write. Send 0x01 -> ignored.
- Send 0x0C mid-line -> full 1200-cycle clear, cursor=(0,0). Assert rst for one cycle at CLRLINE write 20 -> full clear restarts at address 0 and runs 1200 cycles.

Source files
------------

// File: rtl/text_writer.sv
// Byte-stream to text-RAM writer: keeps a terminal cursor, decodes CR/LF/BS/FF,
// clears the whole screen after reset or FF and clears each line as the cursor enters it.
module text_writer #(
  parameter int         COLS       = 40,
  parameter int         ROWS       = 30,
  parameter int         ADDR_WIDTH = 11,
  parameter logic [7:0] BLANK      = 8'h20
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            char_in,
  input  logic                  char_valid,
  output logic                  char_ready,
  output logic [ADDR_WIDTH-1:0] ram_waddr,
  output logic [7:0]            ram_wdata,
  output logic                  ram_we,
  output logic [6:0]            cursor_col,
  output logic [6:0]            cursor_row
);

  localparam logic [1:0] ST_CLEAR   = 2'd0;
  localparam logic [1:0] ST_IDLE    = 2'd1;
  localparam logic [1:0] ST_CLRLINE = 2'd2;

  localparam logic [ADDR_WIDTH-1:0] COLS_A    = ADDR_WIDTH'(COLS);
  localparam logic [ADDR_WIDTH-1:0] LAST_CELL = ADDR_WIDTH'(COLS * ROWS - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_SPAN = ADDR_WIDTH'(COLS - 1);
  localparam logic [6:0]            LAST_COL  = 7'(COLS - 1);
  localparam logic [6:0]            LAST_ROW  = 7'(ROWS - 1);

  logic [1:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_count;
  logic [ADDR_WIDTH-1:0] r_lineBase;
  logic [6:0]            r_col;
  logic [6:0]            r_row;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_waddr;
  logic [7:0]            r_wdata;

  logic                  w_transfer;
  logic                  w_isPrintable;
  logic [6:0]            w_nextRow;
  logic [ADDR_WIDTH-1:0] w_curAddr;
  logic [ADDR_WIDTH-1:0] w_nextBase;

  assign char_ready    = (r_state == ST_IDLE);
  assign w_transfer    = char_valid && char_ready;
  assign w_isPrintable = (char_in >= 8'h20) && (char_in != 8'h7F);
  assign w_nextRow     = (r_row == LAST_ROW) ? 7'd0 : r_row + 7'd1;
  assign w_curAddr     = ADDR_WIDTH'(r_row) * COLS_A + ADDR_WIDTH'(r_col);
  assign w_nextBase    = ADDR_WIDTH'(w_nextRow) * COLS_A;

  // Write-port outputs are registered; ram_we defaults low and is raised only for a real write.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_CLEAR;
      r_count    <= '0;
      r_lineBase <= '0;
      r_col      <= 7'd0;
      r_row      <= 7'd0;
      r_we       <= 1'b0;
      r_waddr    <= '0;
      r_wdata    <= 8'h00;
    end else begin
      r_we <= 1'b0;
      case (r_state)
        ST_CLEAR: begin
          r_we    <= 1'b1;
          r_waddr <= r_count;
          r_wdata <= BLANK;
          r_col   <= 7'd0;
          r_row   <= 7'd0;
          if (r_count == LAST_CELL) begin
            r_state <= ST_IDLE;
            r_count <= '0;
          end else begin
            r_count <= r_count + 1'b1;
          end
        end

        ST_IDLE: begin
          if (w_transfer) begin
            case (char_in)
              8'h0D: r_col <= 7'd0;
              8'h0A: begin
                r_col      <= 7'd0;
                r_row      <= w_nextRow;
                r_lineBase <= w_nextBase;
                r_count    <= '0;
                r_state    <= ST_CLRLINE;
              end
              8'h08: begin
                if (r_col != 7'd0) begin
                  r_col   <= r_col - 7'd1;
                  r_we    <= 1'b1;
                  r_waddr <= w_curAddr - 1'b1;
                  r_wdata <= BLANK;
                end
              end
              8'h0C: begin
                r_col   <= 7'd0;
                r_row   <= 7'd0;
                r_count <= '0;
                r_state <= ST_CLEAR;
              end
              default: begin
                if (w_isPrintable) begin
                  r_we    <= 1'b1;
                  r_waddr <= w_curAddr;
                  r_wdata <= char_in;
                  // Auto-wrap: the character write goes out first, then the new line is blanked.
                  if (r_col == LAST_COL) begin
                    r_col      <= 7'd0;
                    r_row      <= w_nextRow;
                    r_lineBase <= w_nextBase;
                    r_count    <= '0;
                    r_state    <= ST_CLRLINE;
                  end else begin
                    r_col <= r_col + 7'd1;
                  end
                end
              end
            endcase
          end
        end

        ST_CLRLINE: begin
          r_we    <= 1'b1;
          r_waddr <= r_lineBase + r_count;
          r_wdata <= BLANK;
          if (r_count == LAST_SPAN) begin
            r_state <= ST_IDLE;
            r_count <= '0;
          end else begin
            r_count <= r_count + 1'b1;
          end
        end

        default: begin
          r_state <= ST_CLEAR;
          r_count <= '0;
        end
      endcase
    end
  end

  assign ram_we     = r_we;
  assign ram_waddr  = r_waddr;
  assign ram_wdata  = r_wdata;
  assign cursor_col = r_col;
  assign cursor_row = r_row;

endmodule

// File: tb/tb_text_writer.sv
// Self-checking bench for text_writer: a cursor model pushes expected RAM writes into a
// scoreboard, a negedge monitor pops and compares them, directed steps check cursor and timing.
module tb_text_writer;

  localparam int COLS  = 40;
  localparam int ROWS  = 30;
  localparam int AW    = 11;
  localparam int CELLS = COLS * ROWS;

  logic          clk;
  logic          rst;
  logic [7:0]    char_in;
  logic          char_valid;
  logic          char_ready;
  logic [AW-1:0] ram_waddr;
  logic [7:0]    ram_wdata;
  logic          ram_we;
  logic [6:0]    cursor_col;
  logic [6:0]    cursor_row;

  int checks = 0;
  int errors = 0;
  int mCol   = 0;
  int mRow   = 0;

  logic [AW-1:0] expAddr[$];
  logic [7:0]    expData[$];

  text_writer #(
    .COLS(COLS), .ROWS(ROWS), .ADDR_WIDTH(AW), .BLANK(8'h20)
  ) dut (
    .clk(clk), .rst(rst), .char_in(char_in), .char_valid(char_valid),
    .char_ready(char_ready), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
    .ram_we(ram_we), .cursor_col(cursor_col), .cursor_row(cursor_row)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic pushWrite(input int addr, input logic [7:0] data);
    expAddr.push_back(AW'(addr));
    expData.push_back(data);
  endtask

  task automatic pushLine(input int row);
    for (int c = 0; c < COLS; c++) pushWrite(row * COLS + c, 8'h20);
  endtask

  task automatic pushScreen();
    for (int a = 0; a < CELLS; a++) pushWrite(a, 8'h20);
  endtask

  task automatic modelAdvance();
    mRow = (mRow == ROWS - 1) ? 0 : mRow + 1;
    pushLine(mRow);
  endtask

  // Terminal reference behaviour for one accepted byte.
  task automatic modelAccept(input logic [7:0] c);
    if (c == 8'h0D) begin
      mCol = 0;
    end else if (c == 8'h0A) begin
      mCol = 0;
      modelAdvance();
    end else if (c == 8'h08) begin
      if (mCol > 0) begin
        mCol--;
        pushWrite(mRow * COLS + mCol, 8'h20);
      end
    end else if (c == 8'h0C) begin
      mCol = 0;
      mRow = 0;
      pushScreen();
    end else if (c < 8'h20 || c == 8'h7F) begin
      mCol = mCol;
    end else begin
      pushWrite(mRow * COLS + mCol, c);
      if (mCol < COLS - 1) begin
        mCol++;
      end else begin
        mCol = 0;
        modelAdvance();
      end
    end
  endtask

  task automatic applyStimulus(input logic [7:0] c);
    int waited = 0;
    char_in    = c;
    char_valid = 1'b1;
    while (char_ready !== 1'b1 && waited < 3000) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 3000) checkOutput("acceptTimeout", 32'(char_ready), 32'd1);
    modelAccept(c);
    @(negedge clk);
    char_valid = 1'b0;
  endtask

  task automatic checkCursor(input string tag, input int col, input int row);
    checkOutput({tag, "Col"}, 32'(cursor_col), 32'(col));
    checkOutput({tag, "Row"}, 32'(cursor_row), 32'(row));
  endtask

  task automatic resetDut();
    rst = 1'b1;
    @(negedge clk);
    checkOutput("resetWe", 32'(ram_we), 32'd0);
    checkOutput("resetAddr", 32'(ram_waddr), 32'd0);
    checkOutput("resetData", 32'(ram_wdata), 32'd0);
    checkOutput("resetReady", 32'(char_ready), 32'd0);
    checkCursor("reset", 0, 0);
    rst = 1'b0;
    expAddr.delete();
    expData.delete();
    mCol = 0;
    mRow = 0;
    pushScreen();
  endtask

  task automatic clearCheck();
    int n = 0;
    @(negedge clk);
    while (ram_we === 1'b1 && n < CELLS + 100) begin
      checkOutput("clearAddr", 32'(ram_waddr), 32'(n));
      checkOutput("clearData", 32'(ram_wdata), 32'h20);
      if (n < CELLS - 1) checkOutput("clearReady", 32'(char_ready), 32'd0);
      n++;
      @(negedge clk);
    end
    checkOutput("clearLength", 32'(n), 32'(CELLS));
    checkOutput("readyAfterClear", 32'(char_ready), 32'd1);
    checkCursor("afterClear", 0, 0);
  endtask

  task automatic waitIdle();
    int n = 0;
    while (!(char_ready === 1'b1 && ram_we === 1'b0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("idleTimeout", 32'(n < 3000), 32'd1);
    checkOutput("scoreboardDrained", 32'(expAddr.size()), 32'd0);
  endtask

  // Scoreboard monitor: every RAM write must match the oldest expected write.
  initial begin
    forever begin
      @(negedge clk);
      if (ram_we === 1'b1) begin
        checkOutput("writeExpected", 32'(expAddr.size() > 0), 32'd1);
        if (expAddr.size() > 0) begin
          checkOutput("writeAddr", 32'(ram_waddr), 32'(expAddr.pop_front()));
          checkOutput("writeData", 32'(ram_wdata), 32'(expData.pop_front()));
        end
      end
    end
  end

  initial begin
    int n;
    rst        = 1'b1;
    char_in    = 8'h00;
    char_valid = 1'b0;

    resetDut();
    clearCheck();

    applyStimulus(8'h41);
    checkOutput("firstWriteAddr", 32'(ram_waddr), 32'd0);
    checkOutput("firstWriteData", 32'(ram_wdata), 32'h41);
    applyStimulus(8'h42);
    checkOutput("secondWriteWe", 32'(ram_we), 32'd1);
    checkOutput("secondWriteAddr", 32'(ram_waddr), 32'd1);
    checkOutput("secondWriteData", 32'(ram_wdata), 32'h42);
    checkCursor("afterAB", 2, 0);

    applyStimulus(8'h0D);
    checkOutput("crNoWrite", 32'(ram_we), 32'd0);
    checkCursor("afterCr", 0, 0);
    for (int i = 0; i < COLS; i++) applyStimulus(8'h78);
    checkOutput("wrapWriteAddr", 32'(ram_waddr), 32'd39);
    checkCursor("afterWrap", 0, 1);
    n = 0;
    while (char_ready !== 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    checkOutput("clrLineBusyCycles", 32'(n), 32'd40);
    checkOutput("clrLineLastAddr", 32'(ram_waddr), 32'd79);
    waitIdle();

    applyStimulus(8'h0A);
    waitIdle();
    for (int i = 0; i < 5; i++) applyStimulus(8'h61 + 8'(i));
    checkCursor("beforeBs", 5, 2);
    applyStimulus(8'h08);
    checkOutput("bsWe", 32'(ram_we), 32'd1);
    checkOutput("bsAddr", 32'(ram_waddr), 32'd84);
    checkOutput("bsData", 32'(ram_wdata), 32'h20);
    checkCursor("afterBs", 4, 2);
    applyStimulus(8'h0D);
    applyStimulus(8'h08);
    checkOutput("bsAtCol0NoWrite", 32'(ram_we), 32'd0);
    checkCursor("bsAtCol0", 0, 2);

    for (int i = 0; i < 27; i++) applyStimulus(8'h0A);
    waitIdle();
    for (int i = 0; i < 7; i++) applyStimulus(8'h30 + 8'(i));
    checkCursor("beforeLastRowLf", 7, 29);
    applyStimulus(8'h0A);
    checkCursor("lfWrapToTop", 0, 0);
    waitIdle();

    for (int i = 0; i < 3; i++) applyStimulus(8'h0A);
    waitIdle();
    for (int i = 0; i < 9; i++) applyStimulus(8'h4B);
    checkCursor("beforeCr", 9, 3);
    applyStimulus(8'h0D);
    checkOutput("crAt9NoWrite", 32'(ram_we), 32'd0);
    checkCursor("afterCr93", 0, 3);
    applyStimulus(8'h01);
    checkOutput("ctrlIgnoredNoWrite", 32'(ram_we), 32'd0);
    checkCursor("ctrlIgnored", 0, 3);
    applyStimulus(8'h7F);
    checkOutput("delIgnoredNoWrite", 32'(ram_we), 32'd0);
    checkCursor("delIgnored", 0, 3);

    applyStimulus(8'h7A);
    checkCursor("beforeFf", 1, 3);
    applyStimulus(8'h0C);
    checkOutput("ffReady", 32'(char_ready), 32'd0);
    clearCheck();
    waitIdle();

    applyStimulus(8'h0A);
    n = 0;
    while (!(ram_we === 1'b1 && ram_waddr == AW'(60)) && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("reachedClrLineWrite20", 32'(n < 100), 32'd1);
    resetDut();
    clearCheck();
    waitIdle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
